// File: rtl/gray_sync_rx.sv
// Receive side of a gray-coded counter crossing: synchronises a foreign-domain gray value,
// decodes it to binary, reports per-update step size and flags illegal multi-bit transitions.
module gray_sync_rx #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             error_clear,
   output logic [WIDTH-1:0] gray_sync,
   output logic [WIDTH-1:0] binary_out,
   output logic             valid,
   output logic             changed,
   output logic [WIDTH-1:0] delta,
   output logic             error
);

   localparam int CNT_W = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SYNC_STAGES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_FILL  = 2'b00,
      ST_PRIME = 2'b01,
      ST_TRACK = 2'b10
   } state_t;

   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // More than one bit set in d: clearing the lowest set bit leaves something behind.
   function automatic logic multi_bit(input logic [WIDTH-1:0] d);
      return ((d & (d - {{(WIDTH-1){1'b0}}, 1'b1})) != {WIDTH{1'b0}});
   endfunction

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   state_t                            state_r, state_s;
   logic [CNT_W-1:0]                  fill_cnt_r, fill_cnt_s;
   logic [WIDTH-1:0]                  bin_r, bin_s;
   logic [WIDTH-1:0]                  prev_r, prev_s;
   logic [WIDTH-1:0]                  delta_r, delta_s;
   logic                              valid_r, valid_s;
   logic                              changed_r, changed_s;
   logic                              error_r, error_s;
   logic [WIDTH-1:0]                  gray_sync_s;
   logic [WIDTH-1:0]                  decoded_s;

   assign gray_sync_s = sync_r[SYNC_STAGES-1];
   assign decoded_s   = gray_to_bin(gray_sync_s);

   // Synchroniser chain, free-running regardless of FSM state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         sync_r[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_FILL;
         fill_cnt_r <= {CNT_W{1'b0}};
         bin_r      <= {WIDTH{1'b0}};
         prev_r     <= {WIDTH{1'b0}};
         delta_r    <= {WIDTH{1'b0}};
         valid_r    <= 1'b0;
         changed_r  <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         fill_cnt_r <= fill_cnt_s;
         bin_r      <= bin_s;
         prev_r     <= prev_s;
         delta_r    <= delta_s;
         valid_r    <= valid_s;
         changed_r  <= changed_s;
         error_r    <= error_s;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s    = state_r;
      fill_cnt_s = fill_cnt_r;
      bin_s      = bin_r;
      prev_s     = prev_r;
      delta_s    = delta_r;
      valid_s    = valid_r;
      changed_s  = changed_r;
      error_s    = error_r;
      case (state_r)
         ST_FILL: begin
            fill_cnt_s = fill_cnt_r + CNT_ONE;
            if (fill_cnt_r == FILL_LAST) begin
               state_s = ST_PRIME;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_PRIME: begin
            bin_s   = decoded_s;
            prev_s  = gray_sync_s;
            valid_s = 1'b1;
            state_s = ST_TRACK;
         end
         ST_TRACK: begin
            bin_s  = decoded_s;
            prev_s = gray_sync_s;
            if (decoded_s != bin_r) begin
               changed_s = 1'b1;
               delta_s   = decoded_s - bin_r;
            end else begin
               changed_s = 1'b0;
               delta_s   = {WIDTH{1'b0}};
            end
            // A fresh violation wins over a simultaneous clear.
            if (multi_bit(gray_sync_s ^ prev_r)) begin
               error_s = 1'b1;
            end else if (error_clear) begin
               error_s = 1'b0;
            end else begin
               error_s = error_r;
            end
         end
         default: begin
            state_s    = ST_FILL;
            fill_cnt_s = {CNT_W{1'b0}};
            valid_s    = 1'b0;
            changed_s  = 1'b0;
            delta_s    = {WIDTH{1'b0}};
            error_s    = 1'b0;
         end
      endcase
   end

   assign gray_sync  = gray_sync_s;
   assign binary_out = bin_r;
   assign valid      = valid_r;
   assign changed    = changed_r;
   assign delta      = delta_r;
   assign error      = error_r;

endmodule
